// File: rtl/instr_sram_pkg.sv
// Shared types for the instruction SRAM port: in-flight slot kinds and
// the response record carried through the response FIFO.
package instr_sram_pkg;

  typedef enum logic [1:0] {
    IF_NONE,
    IF_READ,
    IF_WRITE,
    IF_ERR
  } inflight_kind_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  // Byte address bits below the word index.
  localparam int WORD_OFFSET = 2;

endpackage

// File: rtl/instr_sram_rsp_fifo.sv
// Small show-ahead response FIFO; the head entry is visible whenever count is non-zero.
module instr_sram_rsp_fifo
  import instr_sram_pkg::*;
#(
  parameter int RSP_DEPTH = 2,
  parameter int PW        = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1,
  parameter int CW        = $clog2(RSP_DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  rsp_t          push_data,
  input  logic          pop,
  output rsp_t          head,
  output logic          valid,
  output logic [CW-1:0] count
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  rsp_t          mem_q [RSP_DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    // A push into a full FIFO is only ever issued alongside a pop.
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign valid = (count_q != '0);
  assign count = count_q;

endmodule

// File: rtl/instr_sram_port.sv
// Request/response front end for the dual-port instruction SRAM macro:
// address checks, macro drive, one-entry in-flight slot and response credits.
module instr_sram_port
  import instr_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic                  req_we,
  input  logic [31:0]           req_wdata,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  output logic                  csb1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] dout1
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  inflight_kind_e        inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  addr_err;
  logic                  fire;
  logic                  rsp_pop;
  logic                  push;
  rsp_t                  push_data;
  rsp_t                  fifo_head;
  logic                  fifo_valid;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           used;

  assign word_addr = req_addr[ADDR_WIDTH+1:WORD_OFFSET];
  assign addr_err  = (req_addr[WORD_OFFSET-1:0] != '0) || (req_addr[31:ADDR_WIDTH+2] != '0);

  // Credits count the in-flight slot so a full FIFO can never be overrun.
  assign used      = (CW+1)'(fifo_count) + (CW+1)'(inflight_q != IF_NONE) - (CW+1)'(rsp_pop);
  assign req_ready = !reset && (used < (CW+1)'(RSP_DEPTH));
  assign fire      = req_valid && req_ready;

  always_comb begin
    csb0       = 1'b1;
    web0       = 1'b1;
    wmask0     = '0;
    addr0      = '0;
    din0       = '0;
    csb1       = 1'b1;
    addr1      = '0;
    inflight_d = IF_NONE;
    if (fire) begin
      if (addr_err) begin
        inflight_d = IF_ERR;
      end else if (req_we) begin
        csb0       = 1'b0;
        web0       = 1'b0;
        wmask0     = req_wmask;
        addr0      = word_addr;
        din0       = req_wdata;
        inflight_d = IF_WRITE;
      end else begin
        csb1       = 1'b0;
        addr1      = word_addr;
        inflight_d = IF_READ;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight_q <= IF_NONE;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    push_data = '0;
    case (inflight_q)
      IF_READ:  push_data.rdata = dout1;
      IF_ERR:   push_data.err   = 1'b1;
      default:  push_data       = '0;
    endcase
  end

  assign push    = (inflight_q != IF_NONE);
  assign rsp_pop = rsp_valid && rsp_ready;

  instr_sram_rsp_fifo #(
    .RSP_DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (rsp_pop),
    .head      (fifo_head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  // Gate the head so stale storage never shows on the bus while empty.
  assign rsp_valid = fifo_valid;
  assign rsp_rdata = fifo_valid ? fifo_head.rdata : '0;
  assign rsp_err   = fifo_valid ? fifo_head.err : 1'b0;

endmodule
